// File: rtl/transport_pkg.sv
// ---------------------------------------------------------------------------
// transport_pkg
// Shared definitions for the transport transmit scheduler:
//   - command codes driven onto the transmitter cmd bus
//   - scheduler FSM state encoding
//   - voice sample width
// ---------------------------------------------------------------------------
package transport_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        CMD_IDLE       = 2'b00,
        CMD_CONNECT    = 2'b01,
        CMD_DISCONNECT = 2'b10,
        CMD_RSVD       = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tx_sample_fifo.sv
// ---------------------------------------------------------------------------
// tx_sample_fifo
// Synchronous FIFO buffering voice samples for the transmit scheduler.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   push, push_data  - write request and sample
//   pop              - read request; head is the sample removed by it
//   head             - current oldest sample (valid when !empty)
//   full, empty      - occupancy flags
//   level            - occupancy, 0..DEPTH
//   drop             - combinational pulse: push refused because full
// A push and a pop in the same cycle are both accepted even when full,
// because the pop frees the slot the push writes into.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module tx_sample_fifo
    import transport_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [SAMPLE_W-1:0]       push_data,
    input  logic                      pop,
    output logic [SAMPLE_W-1:0]       head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      drop
);

    localparam int AW = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through valid entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/transport_tx_sched.sv
// ---------------------------------------------------------------------------
// transport_tx_sched
// Shares one packet transmitter between call control (2-bit commands) and
// voice (16-bit samples buffered in a FIFO). Control has priority, but after
// CTRL_BURST consecutive control grants with voice pending, voice is served.
// Optional macro: TX_SCHED_DROP_CNT_EN adds the drop_count port/counter.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   ctrl_req/ctrl_cmd      - control request, held until ctrl_ack
//   ctrl_ack               - one-cycle pulse when the command is issued
//   aud_strobe/aud_data    - one-cycle push of a voice sample
//   fifo_level             - sample FIFO occupancy
//   tx_cmd/tx_data/tx_send - transmitter cmd, data, sendData (registered)
//   tx_busy                - transmitter busy
//   err_timeout            - one-cycle pulse when busy never rose
//   drop_count             - saturating dropped-sample count (macro only)
//   dbg_state              - current scheduler state
// Handshake: a strobe (tx_cmd != 0 or tx_send) is held for exactly one
// cycle; the transmitter acknowledges by raising tx_busy within ACK_TIMEOUT
// cycles and signals completion by dropping it. A new strobe is only issued
// from IDLE with tx_busy low.
// ---------------------------------------------------------------------------
module transport_tx_sched
    import transport_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CTRL_BURST  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ctrl_req,
    input  logic [1:0]                   ctrl_cmd,
    output logic                         ctrl_ack,
    input  logic                         aud_strobe,
    input  logic [SAMPLE_W-1:0]          aud_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [1:0]                   tx_cmd,
    output logic [SAMPLE_W-1:0]          tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy,
    output logic                         err_timeout,
`ifdef TX_SCHED_DROP_CNT_EN
    output logic [7:0]                   drop_count,
`endif
    output logic [1:0]                   dbg_state
);

    localparam int BW = $clog2(CTRL_BURST + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    sched_state_e        state, state_nxt;
    logic [BW-1:0]       burst_cnt, burst_nxt;
    logic [TW-1:0]       ack_cnt, ack_nxt;
    logic [1:0]          tx_cmd_nxt;
    logic [SAMPLE_W-1:0] tx_data_nxt;
    logic                tx_send_nxt, ctrl_ack_nxt, err_nxt;

    logic                fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                have_work, voice_win;
    logic                unused_fifo;

    tx_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (aud_strobe),
        .push_data (aud_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .drop      (fifo_drop)
    );

    assign unused_fifo = fifo_full ^ fifo_drop;
    assign dbg_state   = state;

    assign have_work = ctrl_req || !fifo_empty;
    // Voice preempts control only once control has used up its burst.
    assign voice_win = !fifo_empty && (!ctrl_req || (burst_cnt == BW'(CTRL_BURST)));

    always_comb begin
        state_nxt    = state;
        burst_nxt    = burst_cnt;
        ack_nxt      = ack_cnt;
        tx_cmd_nxt   = CMD_IDLE;
        tx_data_nxt  = tx_data;
        tx_send_nxt  = 1'b0;
        ctrl_ack_nxt = 1'b0;
        err_nxt      = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            IDLE: begin
                // Grant outputs are registered on the edge entering ISSUE,
                // so they are visible for exactly the ISSUE cycle.
                if (!tx_busy && have_work) begin
                    state_nxt = ISSUE;
                    if (voice_win) begin
                        fifo_pop    = 1'b1;
                        tx_data_nxt = fifo_head;
                        tx_send_nxt = 1'b1;
                        burst_nxt   = '0;
                    end else begin
                        tx_cmd_nxt   = ctrl_cmd;
                        ctrl_ack_nxt = 1'b1;
                        if (burst_cnt != BW'(CTRL_BURST)) burst_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
                ack_nxt   = TW'(1);
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == TW'(ACK_TIMEOUT)) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    ack_nxt = ack_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // No voice pending means control owes nothing; restart the burst.
        if (fifo_empty) burst_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            ack_cnt     <= '0;
            tx_cmd      <= CMD_IDLE;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            ctrl_ack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_nxt;
            ack_cnt     <= ack_nxt;
            tx_cmd      <= tx_cmd_nxt;
            tx_data     <= tx_data_nxt;
            tx_send     <= tx_send_nxt;
            ctrl_ack    <= ctrl_ack_nxt;
            err_timeout <= err_nxt;
        end
    end

`ifdef TX_SCHED_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (fifo_drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_transport_tx_sched.sv
module tb_transport_tx_sched;
  import transport_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        ctrl_req = 1'b0;
  logic [1:0]  ctrl_cmd = 2'b00;
  logic        ctrl_ack;
  logic        aud_strobe = 1'b0;
  logic [15:0] aud_data = 16'h0;
  logic [2:0]  fifo_level;
  logic [1:0]  tx_cmd;
  logic [15:0] tx_data;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic        err_timeout;
  logic [1:0]  dbg_state;
`ifdef TX_SCHED_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  transport_tx_sched #(.FIFO_DEPTH(4), .CTRL_BURST(2), .ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_req    (ctrl_req),
    .ctrl_cmd    (ctrl_cmd),
    .ctrl_ack    (ctrl_ack),
    .aud_strobe  (aud_strobe),
    .aud_data    (aud_data),
    .fifo_level  (fifo_level),
    .tx_cmd      (tx_cmd),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout),
`ifdef TX_SCHED_DROP_CNT_EN
    .drop_count  (drop_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / reference model state ----------------
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int model_drops = 0;
  logic [1:0] cmd_exp = 2'b00;
  int cmds_left = 0;
  int n_sends = 0;
  int n_acks = 0;
  int n_grants = 0;
  int grant_bits = 0;
  int send_cyc[$];
  int err_cyc[$];
  int ack_cyc_last = 0;
  // transmitter model
  bit force_busy = 1'b0;
  bit resp_en = 1'b1;
  bit model_busy = 1'b0;
  bit start_pend = 1'b0;
  int busy_rem = 0;
  int busy_len = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_busy();
    tx_busy = force_busy || model_busy;
  endtask

  // Called #1 after each rising edge: scoreboard the events of the edge just
  // passed, then decide the transmitter's busy line for the next edge.
  task automatic observe();
    check("cmd_send_exclusive", 32'(tx_send && (tx_cmd != 2'b00)), 32'd0);
    check("cmd_only_with_ack", 32'(tx_cmd != 2'b00), 32'(ctrl_ack));
    if (tx_send) begin
      n_sends++;
      n_grants++;
      grant_bits = (grant_bits << 1) | 1;
      send_cyc.push_back(cyc);
      check("send_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("send_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (ctrl_ack) begin
      n_acks++;
      n_grants++;
      grant_bits = grant_bits << 1;
      ack_cyc_last = cyc;
      check("ack_req_held", 32'(ctrl_req), 32'd1);
      check("ack_cmd", 32'(tx_cmd), 32'(cmd_exp));
      cmds_left--;
      if (cmds_left <= 0) ctrl_req = 1'b0;
    end
    if (aud_strobe) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(aud_data);
      else model_drops++;
      aud_strobe = 1'b0;
    end
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
`ifdef TX_SCHED_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'((model_drops > 255) ? 255 : model_drops));
`endif
    if (err_timeout) err_cyc.push_back(cyc);
    if (start_pend) begin
      busy_rem = busy_len;
      start_pend = 1'b0;
    end
    if (resp_en && (tx_send || ctrl_ack)) start_pend = 1'b1;
    model_busy = (busy_rem > 0);
    if (busy_rem > 0) busy_rem--;
    update_busy();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic push(input logic [15:0] d);
    aud_data = d;
    aud_strobe = 1'b1;
    cycle();
  endtask

  task automatic request(input logic [1:0] c, input int n);
    ctrl_cmd = c;
    cmd_exp = c;
    cmds_left = n;
    ctrl_req = 1'b1;
  endtask

  task automatic settle(input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && !(exp_q.size() == 0 && !ctrl_req && dbg_state == 2'(IDLE) &&
                           !tx_busy && !start_pend && busy_rem == 0)) begin
      cycle();
      k++;
    end
    check({tag, "_settle"}, 32'(k < budget), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_cmd"}, 32'(tx_cmd), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_ctrl_ack"}, 32'(ctrl_ack), 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
`ifdef TX_SCHED_DROP_CNT_EN
    check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p0, a0, s0, e0, k;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // voice only
    send_cyc.delete();
    grant_bits = 0; n_grants = 0;
    push(16'h8000);
    p0 = cyc;
    push(16'h8001);
    push(16'h8002);
    settle(100, "voice");
    check("voice_send_count", 32'(send_cyc.size()), 32'd3);
    check("voice_order", 32'(grant_bits), 32'b111);
    if (send_cyc.size() == 3) begin
      check("voice_first_latency", 32'(send_cyc[0]), 32'(p0 + 1));
      for (int i = 1; i < 3; i++)
        check("voice_spacing", 32'(send_cyc[i] - send_cyc[i-1] >= 4), 32'd1);
    end
    check("voice_tx_data_hold", 32'(tx_data), 32'h8002);

    // control priority and fairness
    force_busy = 1'b1; update_busy();
    push(16'hA001);
    push(16'hA002);
    grant_bits = 0; n_grants = 0;
    request(CMD_CONNECT, 4);
    force_busy = 1'b0; update_busy();
    settle(200, "fair");
    check("fair_grant_count", 32'(n_grants), 32'd6);
    check("fair_order", 32'(grant_bits), 32'b001001);

    // overflow
    force_busy = 1'b1; update_busy();
    for (int i = 0; i < 6; i++) push(16'h0B00 + 16'(i));
    check("ovf_level", 32'(fifo_level), 32'd4);
`ifdef TX_SCHED_DROP_CNT_EN
    check("ovf_drop_count", 32'(drop_count), 32'd2);
`endif
    s0 = n_sends;
    force_busy = 1'b0; update_busy();
    settle(200, "ovf");
    check("ovf_sent", 32'(n_sends - s0), 32'd4);

    // ACK timeout
    resp_en = 1'b0;
    err_cyc.delete();
    a0 = n_acks;
    request(CMD_DISCONNECT, 1);
    k = 0;
    while (n_acks == a0 && k < 30) begin cycle(); k++; end
    check("tmo_ack_seen", 32'(n_acks - a0), 32'd1);
    k = 0;
    while (err_cyc.size() == 0 && k < 40) begin cycle(); k++; end
    check("tmo_fired", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() > 0) check("tmo_cycle", 32'(err_cyc[0]), 32'(ack_cyc_last + 16));
    repeat (3) cycle();
    check("tmo_single_pulse", 32'(err_cyc.size()), 32'd1);
    resp_en = 1'b1;
    a0 = n_acks;
    request(CMD_CONNECT, 1);
    settle(100, "tmo_next");
    check("tmo_next_served", 32'(n_acks - a0), 32'd1);
    check("tmo_no_extra_err", 32'(err_cyc.size()), 32'd1);

    // reset in WAIT_DONE with three samples buffered
    busy_len = 30;
    request(CMD_CONNECT, 1);
    push(16'hD001);
    push(16'hD002);
    push(16'hD003);
    k = 0;
    while (dbg_state != 2'(WAIT_DONE) && k < 20) begin cycle(); k++; end
    check("mid_in_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    check("mid_level", 32'(fifo_level), 32'd3);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    model_drops = 0;
    busy_rem = 0; start_pend = 1'b0; model_busy = 1'b0; force_busy = 1'b0;
    ctrl_req = 1'b0; busy_len = 3;
    update_busy();
    @(posedge clk);
    #2;
    reset = 1'b1;
    s0 = n_sends;
    repeat (20) cycle();
    check("mid_no_send", 32'(n_sends - s0), 32'd0);
    push(16'hE123);
    settle(50, "mid_after");
    check("mid_send_after_push", 32'(n_sends - s0), 32'd1);

    // simultaneous push and pop while full
    force_busy = 1'b1; update_busy();
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
    check("simul_full", 32'(fifo_level), 32'd4);
    e0 = model_drops;
    force_busy = 1'b0; update_busy();
    push(16'hC004);
    check("simul_pop", 32'(tx_send), 32'd1);
    check("simul_level", 32'(fifo_level), 32'd4);
    check("simul_no_drop_model", 32'(model_drops - e0), 32'd0);
`ifdef TX_SCHED_DROP_CNT_EN
    check("simul_drop_count", 32'(drop_count), 32'd0);
`endif
    settle(200, "simul");

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      busy_len = int'($urandom_range(1, 4));
      if (!ctrl_req && $urandom_range(0, 7) == 0)
        request(2'($urandom_range(1, 3)), 1);
      if ($urandom_range(0, 2) == 0) push(16'($urandom));
      else cycle();
    end
    settle(400, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
